// File: rtl/easyaxi_pkg.sv
// Shared EasyAXI encodings and default widths for the fabric masters and slaves.
package easyaxi_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [2:0] AXI_SIZE_8B = 3'b011;

  // Merged burst response: the numerically worst code seen so far.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/easyaxi_ffs_lowest.sv
// Lowest-set-bit priority encoder; idx is 0 when no bit is set.
module easyaxi_ffs_lowest #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign found = |req;

endmodule

// File: rtl/easyaxi_rd_mst_ost.sv
// AXI read master with one outstanding burst per tracking entry; R beats may
// return out of order across IDs and are checked against each entry's state.
module easyaxi_rd_mst_ost
  import easyaxi_pkg::*;
#(
  parameter int unsigned OST_DEPTH = 4,
  parameter int unsigned ID_W      = AXI_ID_W,
  parameter int unsigned ADDR_W    = AXI_ADDR_W,
  parameter int unsigned LEN_W     = AXI_LEN_W,
  parameter int unsigned DATA_W    = AXI_DATA_W,
  parameter logic [2:0]  SIZE      = AXI_SIZE_4B
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ADDR_W-1:0]              cmd_addr,
  input  logic [LEN_W-1:0]               cmd_len,
  output logic                           axi_mst_arvalid,
  input  logic                           axi_mst_arready,
  output logic [ID_W-1:0]                axi_mst_arid,
  output logic [ADDR_W-1:0]              axi_mst_araddr,
  output logic [LEN_W-1:0]               axi_mst_arlen,
  output logic [2:0]                     axi_mst_arsize,
  output logic [1:0]                     axi_mst_arburst,
  input  logic                           axi_mst_rvalid,
  output logic                           axi_mst_rready,
  input  logic [ID_W-1:0]                axi_mst_rid,
  input  logic [DATA_W-1:0]              axi_mst_rdata,
  input  logic [1:0]                     axi_mst_rresp,
  input  logic                           axi_mst_rlast,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_data_vld,
  output logic                           comp_vld,
  output logic [ID_W-1:0]                comp_id,
  output logic [1:0]                     comp_resp,
  output logic [7:0]                     err_cnt,
  output logic                           proto_err,
  output logic [$clog2(OST_DEPTH):0]     outstanding
);

  localparam int unsigned IDX_W = $clog2(OST_DEPTH);

  logic [OST_DEPTH-1:0] vld_q, req_q, comp_q;
  logic [ADDR_W-1:0]    addr_q [OST_DEPTH];
  logic [LEN_W-1:0]     len_q  [OST_DEPTH];
  logic [LEN_W:0]       cnt_q  [OST_DEPTH];
  logic [1:0]           resp_q [OST_DEPTH];

  logic             hold_q;
  logic [IDX_W-1:0] hold_idx_q;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_data_vld_q, comp_vld_q, proto_err_q;
  logic [ID_W-1:0]   comp_id_q;
  logic [1:0]        comp_resp_q;
  logic [7:0]        err_cnt_q;

  logic [IDX_W-1:0] alloc_idx, issue_idx, ar_sel, r_idx;
  logic             alloc_found, issue_found;
  logic             r_ok, r_beat, r_at_len, r_proto;
  logic [1:0]       r_merged;

  easyaxi_ffs_lowest #(.WIDTH(OST_DEPTH), .IDX_W(IDX_W)) u_alloc (
    .req   (~vld_q),
    .idx   (alloc_idx),
    .found (alloc_found)
  );

  easyaxi_ffs_lowest #(.WIDTH(OST_DEPTH), .IDX_W(IDX_W)) u_issue (
    .req   (req_q),
    .idx   (issue_idx),
    .found (issue_found)
  );

  // A stalled request keeps its entry even if a lower one becomes pending.
  assign ar_sel          = hold_q ? hold_idx_q : issue_idx;
  assign axi_mst_arvalid = issue_found;
  assign axi_mst_arid    = axi_mst_arvalid ? ID_W'(ar_sel) : '0;
  assign axi_mst_araddr  = axi_mst_arvalid ? addr_q[ar_sel] : '0;
  assign axi_mst_arlen   = axi_mst_arvalid ? len_q[ar_sel] : '0;
  assign axi_mst_arsize  = SIZE;
  assign axi_mst_arburst = AXI_BURST_INCR;
  assign axi_mst_rready  = 1'b1;
  assign cmd_ready       = alloc_found;

  assign r_idx    = axi_mst_rid[IDX_W-1:0];
  assign r_ok     = ((axi_mst_rid >> IDX_W) == '0) && comp_q[r_idx] && !req_q[r_idx];
  assign r_beat   = axi_mst_rvalid && r_ok;
  assign r_at_len = (cnt_q[r_idx] == {1'b0, len_q[r_idx]});
  assign r_merged = resp_max(resp_q[r_idx], axi_mst_rresp);
  assign r_proto  = (axi_mst_rvalid && !r_ok) ||
                    (r_beat && (axi_mst_rlast ? !r_at_len : r_at_len));

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < OST_DEPTH; i++) begin
      outstanding = outstanding + (IDX_W + 1)'(vld_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q         <= '0;
      req_q         <= '0;
      comp_q        <= '0;
      hold_q        <= 1'b0;
      hold_idx_q    <= '0;
      for (int i = 0; i < OST_DEPTH; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= '0;
        cnt_q[i]  <= '0;
        resp_q[i] <= AXI_RESP_OKAY;
      end
      rd_data_q     <= '0;
      rd_data_vld_q <= 1'b0;
      comp_vld_q    <= 1'b0;
      comp_id_q     <= '0;
      comp_resp_q   <= AXI_RESP_OKAY;
      err_cnt_q     <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        vld_q[alloc_idx]  <= 1'b1;
        req_q[alloc_idx]  <= 1'b1;
        comp_q[alloc_idx] <= 1'b1;
        addr_q[alloc_idx] <= cmd_addr;
        len_q[alloc_idx]  <= cmd_len;
        cnt_q[alloc_idx]  <= '0;
        resp_q[alloc_idx] <= AXI_RESP_OKAY;
      end

      if (axi_mst_arvalid) begin
        if (axi_mst_arready) begin
          req_q[ar_sel] <= 1'b0;
          hold_q        <= 1'b0;
        end else begin
          hold_q     <= 1'b1;
          hold_idx_q <= ar_sel;
        end
      end

      rd_data_vld_q <= r_beat;
      comp_vld_q    <= 1'b0;
      if (r_beat) begin
        rd_data_q     <= axi_mst_rdata;
        resp_q[r_idx] <= r_merged;
        if (cnt_q[r_idx] != '1) cnt_q[r_idx] <= cnt_q[r_idx] + {{LEN_W{1'b0}}, 1'b1};
        if (axi_mst_rlast) begin
          vld_q[r_idx]  <= 1'b0;
          comp_q[r_idx] <= 1'b0;
          comp_vld_q    <= 1'b1;
          comp_id_q     <= ID_W'(r_idx);
          comp_resp_q   <= r_merged;
          if (r_merged != AXI_RESP_OKAY && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
        end
      end

      if (r_proto) proto_err_q <= 1'b1;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_data_vld = rd_data_vld_q;
  assign comp_vld    = comp_vld_q;
  assign comp_id     = comp_id_q;
  assign comp_resp   = comp_resp_q;
  assign err_cnt     = err_cnt_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_easyaxi_rd_mst_ost.sv
// Scoreboard bench for easyaxi_rd_mst_ost: AR, read data and completions are
// predicted when stimulus is driven and checked when the DUT produces them.
module tb_easyaxi_rd_mst_ost;

  localparam int OST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        arvalid, arready = 1'b0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic [31:0] rd_data;
  logic        rd_data_vld, comp_vld, proto_err;
  logic [3:0]  comp_id;
  logic [1:0]  comp_resp;
  logic [7:0]  err_cnt;
  logic [2:0]  outstanding;

  easyaxi_rd_mst_ost u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .axi_mst_arvalid (arvalid),
    .axi_mst_arready (arready),
    .axi_mst_arid    (arid),
    .axi_mst_araddr  (araddr),
    .axi_mst_arlen   (arlen),
    .axi_mst_arsize  (arsize),
    .axi_mst_arburst (arburst),
    .axi_mst_rvalid  (rvalid),
    .axi_mst_rready  (rready),
    .axi_mst_rid     (rid),
    .axi_mst_rdata   (rdata),
    .axi_mst_rresp   (rresp),
    .axi_mst_rlast   (rlast),
    .rd_data         (rd_data),
    .rd_data_vld     (rd_data_vld),
    .comp_vld        (comp_vld),
    .comp_id         (comp_id),
    .comp_resp       (comp_resp),
    .err_cnt         (err_cnt),
    .proto_err       (proto_err),
    .outstanding     (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int id; logic [1:0] resp; int err; } comp_t;

  ar_t         ar_q[$];
  comp_t       comp_q[$];
  logic [31:0] rd_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the entry table (main process only, except issued_cnt).
  bit         model_busy [OST];
  int         alloc_cnt  [OST];
  int         issued_cnt [OST];
  int         model_cnt  [OST];
  logic [7:0] model_len  [OST];
  logic [1:0] exp_resp   [OST];
  int         exp_err = 0;
  logic       exp_proto = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  bit          prev_stall = 1'b0;
  logic [3:0]  prev_arid;
  logic [31:0] prev_araddr;
  logic [7:0]  prev_arlen;

  always @(negedge clk) begin
    ar_t   a;
    comp_t c;
    if (rst_n && arvalid && arready) begin
      if (ar_q.size() == 0) begin
        check_val("ar_unexp", arvalid, 0);
      end else begin
        a = ar_q.pop_front();
        check_val("ar_id", arid, a.id);
        check_val("ar_addr", araddr, a.addr);
        check_val("ar_len", arlen, a.len);
        issued_cnt[a.id]++;
      end
    end
    if (prev_stall && arvalid) begin
      check_val("ar_hold_id", arid, prev_arid);
      check_val("ar_hold_addr", araddr, prev_araddr);
      check_val("ar_hold_len", arlen, prev_arlen);
    end
    prev_stall  = rst_n && arvalid && !arready;
    prev_arid   = arid;
    prev_araddr = araddr;
    prev_arlen  = arlen;
    if (rd_data_vld) begin
      if (rd_q.size() == 0) check_val("rd_unexp", rd_data_vld, 0);
      else check_val("rd_data", rd_data, rd_q.pop_front());
    end
    if (comp_vld) begin
      if (comp_q.size() == 0) begin
        check_val("comp_unexp", comp_vld, 0);
      end else begin
        c = comp_q.pop_front();
        check_val("comp_id", comp_id, c.id);
        check_val("comp_resp", comp_resp, c.resp);
        check_val("err_cnt", err_cnt, c.err);
      end
    end
  end

  task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len);
    bit ok = 1'b0;
    int id = -1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      check_val("cmd_timeout", cmd_ready, 1);
    end else begin
      for (int i = OST - 1; i >= 0; i--) if (!model_busy[i]) id = i;
      if (id < 0) begin
        check_val("alloc_full", cmd_ready, 0);
      end else begin
        model_busy[id] = 1'b1;
        alloc_cnt[id]++;
        model_cnt[id] = 0;
        model_len[id] = len;
        exp_resp[id]  = 2'b00;
        ar_q.push_back('{id: id, addr: addr, len: len});
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_issued(input int id);
    for (int i = 0; i < 50; i++) begin
      if (issued_cnt[id] == alloc_cnt[id]) break;
      tick();
    end
    check_val("ar_issued", issued_cnt[id], alloc_cnt[id]);
  endtask

  task automatic send_beat(input int id, input logic [31:0] data, input logic [1:0] resp,
                           input logic last);
    bit good = 1'b0;
    if (id < OST) good = model_busy[id] && (issued_cnt[id] == alloc_cnt[id]);
    rvalid = 1'b1;
    rid    = id[3:0];
    rdata  = data;
    rresp  = resp;
    rlast  = last;
    if (good) begin
      rd_q.push_back(data);
      if (resp > exp_resp[id]) exp_resp[id] = resp;
      if (last ? (model_cnt[id] != int'(model_len[id])) : (model_cnt[id] == int'(model_len[id])))
        exp_proto = 1'b1;
      model_cnt[id]++;
      if (last) begin
        if (exp_resp[id] != 2'b00) exp_err++;
        comp_q.push_back('{id: id, resp: exp_resp[id], err: exp_err});
        model_busy[id] = 1'b0;
      end
    end else begin
      exp_proto = 1'b1;
    end
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_cmd_ready"}, cmd_ready, 1);
    check_val({pfx, "_arvalid"}, arvalid, 0);
    check_val({pfx, "_arid"}, arid, 0);
    check_val({pfx, "_araddr"}, araddr, 0);
    check_val({pfx, "_arlen"}, arlen, 0);
    check_val({pfx, "_arsize"}, arsize, 3'b010);
    check_val({pfx, "_arburst"}, arburst, 2'b01);
    check_val({pfx, "_rready"}, rready, 1);
    check_val({pfx, "_rd_data"}, rd_data, 0);
    check_val({pfx, "_rd_data_vld"}, rd_data_vld, 0);
    check_val({pfx, "_comp_vld"}, comp_vld, 0);
    check_val({pfx, "_comp_id"}, comp_id, 0);
    check_val({pfx, "_comp_resp"}, comp_resp, 0);
    check_val({pfx, "_err_cnt"}, err_cnt, 0);
    check_val({pfx, "_proto_err"}, proto_err, 0);
    check_val({pfx, "_outstanding"}, outstanding, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < OST; i++) begin
      model_busy[i] = 1'b0;
      alloc_cnt[i]  = 0;
      issued_cnt[i] = 0;
      model_cnt[i]  = 0;
      model_len[i]  = '0;
      exp_resp[i]   = 2'b00;
    end
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Single command, slave always ready.
    arready = 1'b1;
    send_cmd(32'h100, 8'd3);
    check_val("t1_arvalid", arvalid, 1);
    check_val("t1_outstanding", outstanding, 1);
    wait_issued(0);
    send_beat(0, 32'hA0, 2'b00, 1'b0);
    send_beat(0, 32'hA1, 2'b00, 1'b0);
    send_beat(0, 32'hA2, 2'b00, 1'b0);
    send_beat(0, 32'hA3, 2'b00, 1'b1);
    check_val("t1_comp_vld", comp_vld, 1);
    tick();
    check_val("t1_comp_pulse", comp_vld, 0);
    check_val("t1_outstanding_end", outstanding, 0);

    // Four back-to-back commands with AR stalled.
    arready = 1'b0;
    send_cmd(32'h1000, 8'd1);
    send_cmd(32'h2000, 8'd3);
    send_cmd(32'h3000, 8'd1);
    send_cmd(32'h4000, 8'd1);
    check_val("t2_cmd_ready", cmd_ready, 0);
    check_val("t2_outstanding", outstanding, 4);
    repeat (5) tick();
    check_val("t2_arvalid_stall", arvalid, 1);
    arready = 1'b1;
    wait_issued(3);
    check_val("t2_ar_q_empty", ar_q.size(), 0);

    // Out-of-order return 2, 0, 3, 1 with a reallocation of entry 2.
    send_beat(2, 32'h2000_0000, 2'b00, 1'b0);
    send_beat(0, 32'h0000_0000, 2'b00, 1'b0);
    send_beat(2, 32'h2000_0001, 2'b00, 1'b1);
    check_val("t3_cmd_ready_after_free", cmd_ready, 1);
    check_val("t3_outstanding", outstanding, 3);
    send_cmd(32'h500, 8'd0);
    send_beat(3, 32'h3000_0000, 2'b00, 1'b0);
    send_beat(0, 32'h0000_0001, 2'b00, 1'b1);
    send_beat(3, 32'h3000_0001, 2'b00, 1'b1);
    send_beat(1, 32'h1000_0000, 2'b00, 1'b0);
    send_beat(1, 32'h1000_0001, 2'b10, 1'b0);
    send_beat(1, 32'h1000_0002, 2'b00, 1'b0);
    send_beat(1, 32'h1000_0003, 2'b00, 1'b1);
    check_val("t4_err_cnt", err_cnt, 1);
    check_val("t4_proto_clean", proto_err, exp_proto);
    wait_issued(2);
    send_beat(2, 32'h5000_0000, 2'b01, 1'b1);
    check_val("t3_err_cnt_exokay", err_cnt, 2);
    tick();
    check_val("t3_outstanding_end", outstanding, 0);

    // Early rlast, then beats for an unallocated and an out-of-range ID.
    send_cmd(32'h600, 8'd3);
    wait_issued(0);
    send_beat(0, 32'h6000_0000, 2'b00, 1'b0);
    send_beat(0, 32'h6000_0001, 2'b00, 1'b1);
    check_val("t5_proto_early_last", proto_err, exp_proto);
    send_beat(3, 32'hDEAD_0003, 2'b00, 1'b1);
    send_beat(5, 32'hDEAD_0005, 2'b00, 1'b1);
    repeat (3) tick();
    check_val("t5_proto_sticky", proto_err, exp_proto);
    check_val("t5_outstanding", outstanding, 0);

    // Reset in the middle of a burst.
    send_cmd(32'h700, 8'd3);
    wait_issued(0);
    send_beat(0, 32'h7000_0000, 2'b00, 1'b0);
    send_beat(0, 32'h7000_0001, 2'b00, 1'b0);
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < OST; i++) model_busy[i] = 1'b0;
    exp_err   = 0;
    exp_proto = 1'b0;
    check_reset_vals("t6");
    rst_n = 1'b1;
    tick();
    send_beat(0, 32'h7000_0002, 2'b00, 1'b0);
    check_val("t6_proto_after_rst", proto_err, exp_proto);
    send_cmd(32'h800, 8'd0);
    wait_issued(0);
    send_beat(0, 32'h8000_0000, 2'b00, 1'b1);
    repeat (2) tick();

    check_val("end_outstanding", outstanding, 0);
    check_val("end_ar_q", ar_q.size(), 0);
    check_val("end_rd_q", rd_q.size(), 0);
    check_val("end_comp_q", comp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
